// File: rtl/riscvibe_pkg.sv
// Shared types for the instruction prefetch buffer.
// FSM state, FIFO entry layout and queue pointer helpers.
package riscvibe_pkg;

  localparam int IFB_MAX_DEPTH = 8;
  localparam int IFB_PTR_W = $clog2(IFB_MAX_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } ifb_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ifb_entry_t;

  function automatic logic [31:0] ifb_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [IFB_PTR_W-1:0] ifb_ptr_inc(
    input logic [IFB_PTR_W-1:0] p,
    input int depth
  );
    return (p == IFB_PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO of {pc, data} words for the prefetch buffer.
// Flush empties it in one cycle and wins over push/pop.
module ifb_fifo
  import riscvibe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  ifb_entry_t                 wdata,
  input  logic                       pop,
  output ifb_entry_t                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  ifb_entry_t           mem [IFB_MAX_DEPTH];
  logic [IFB_PTR_W-1:0] wp;
  logic [IFB_PTR_W-1:0] rp;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rp];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= ifb_ptr_inc(wp, DEPTH);
      if (do_pop)  rp <= ifb_ptr_inc(rp, DEPTH);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer with redirect flush and stale-response drop.
// IFB_BYPASS_EN: present a response on instr_* in its arrival cycle.
module instr_prefetch_buffer
  import riscvibe_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  ifb_state_t           state;
  ifb_state_t           state_nx;
  logic [31:0]          fetch_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        discard_cnt;
  logic [CW-1:0]        discard_nx;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          inflight;
  logic [31:0]          pcq [IFB_MAX_DEPTH];
  logic [IFB_PTR_W-1:0] pcq_wp;
  logic [IFB_PTR_W-1:0] pcq_rp;
  logic                 req_acc;
  logic                 rsp_ok;
  logic                 rsp_live;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_vis;
  ifb_entry_t           fifo_wdata;
  ifb_entry_t           fifo_rdata;

  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};

  assign mem_req_valid = !rst && (state == FETCH) && !redirect_valid
                      && (inflight < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_acc       = mem_req_valid && mem_req_ready;

  assign rsp_ok   = !rst && mem_rsp_valid && (outstanding != '0);
  assign rsp_live = rsp_ok && !redirect_valid && (discard_cnt == '0);

  assign fifo_wdata = '{pc: pcq[pcq_rp], data: mem_rsp_data};
  assign fifo_vis   = !rst && !fifo_empty;
  assign pop        = fifo_vis && instr_ready;

`ifdef IFB_BYPASS_EN
  logic byp;
  assign byp         = rsp_live && fifo_empty;
  assign push        = rsp_live && !(byp && instr_ready);
  assign instr_valid = fifo_vis || byp;
  assign instr_data  = fifo_vis ? fifo_rdata.data
                     : byp ? mem_rsp_data : '0;
  assign instr_pc    = fifo_vis ? fifo_rdata.pc
                     : byp ? pcq[pcq_rp] : '0;
`else
  assign push        = rsp_live;
  assign instr_valid = fifo_vis;
  assign instr_data  = fifo_vis ? fifo_rdata.data : '0;
  assign instr_pc    = fifo_vis ? fifo_rdata.pc : '0;
`endif

  ifb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .wdata(fifo_wdata),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Next state and stale-response budget
  always_comb begin
    state_nx   = state;
    discard_nx = discard_cnt;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: state_nx = FETCH;
      FLUSH: begin
        discard_nx = discard_cnt - CW'(rsp_ok);
        if (discard_nx == '0) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
    if (redirect_valid) begin
      discard_nx = outstanding + CW'(req_acc) - CW'(rsp_ok);
      state_nx   = (discard_nx != '0) ? FLUSH : FETCH;
    end
  end

  // State, fetch address and in-flight accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      pcq_wp      <= '0;
      pcq_rp      <= '0;
    end else begin
      state       <= state_nx;
      discard_cnt <= discard_nx;
      outstanding <= outstanding + CW'(req_acc) - CW'(rsp_ok);
      if (redirect_valid) fetch_pc <= ifb_align(redirect_pc);
      else if (req_acc)   fetch_pc <= fetch_pc + 32'd4;
      if (req_acc) pcq_wp <= ifb_ptr_inc(pcq_wp, DEPTH);
      if (rsp_ok)  pcq_rp <= ifb_ptr_inc(pcq_rp, DEPTH);
    end
  end

  // PC of every accepted request, in issue order
  always_ff @(posedge clk) begin
    if (!rst && req_acc) pcq[pcq_wp] <= fetch_pc;
  end

  // A response with nothing in flight means the memory broke protocol
  a_rsp_orphan: assert property (
    @(posedge clk) disable iff (rst)
    !(mem_rsp_valid && outstanding == '0)
  ) else $error("ifb: response with no outstanding request");

  // Request throttling must keep the FIFO from ever overrunning
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && fifo_full)
  ) else $error("ifb: push into full fifo");

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer (DEPTH=2, RESET_PC=0x100).
// Memory model answers in order; monitor checks every consumed word.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  instr_prefetch_buffer #(
    .DEPTH(2),
    .RESET_PC(RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rand_mem = 0;
  int          since_rel = -1;
  int          first_valid = -1;
  int          hs = 0;
  bit          hold_v = 0;
  logic [31:0] hold_a = '0;
  logic [31:0] exp_next = '0;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic retarget(input logic [31:0] base);
    exp_q.delete();
    exp_next = {base[31:2], 2'b00};
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: in-order responses, one per cycle, at least one cycle late
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_req_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_req_ready = rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rst) pend.delete();
      if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mdata(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  // Monitor: request capture, protocol checks, scoreboard compare
  initial begin
    int l;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        since_rel   = -1;
        first_valid = -1;
        hold_v      = 0;
        retarget(RPC);
      end else begin
        since_rel++;
        if (instr_valid && first_valid < 0) first_valid = since_rel;
        if (hold_v && !redirect_valid) begin
          chk("req_hold_valid", 32'(mem_req_valid), 1);
          chk("req_hold_addr", mem_req_addr, hold_a);
        end
        hold_v = mem_req_valid && !mem_req_ready;
        hold_a = mem_req_addr;
        if (redirect_valid)
          chk("no_req_on_redirect", 32'(mem_req_valid), 0);
        if (mem_req_valid && mem_req_ready) begin
          l = rand_mem ? int'($urandom_range(1, 5)) : lat;
          pend.push_back('{mem_req_addr, cyc + l});
          acc_log.push_back(mem_req_addr);
        end
        if (instr_valid && instr_ready) begin
          hs++;
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr_data", instr_data, mdata(e));
          topup();
        end
        if (redirect_valid) retarget(redirect_pc);
      end
    end
  end

  // Directed phases followed by a randomized soak
  initial begin
    int n;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr_data", instr_data, 0);
    chk("rst_instr_pc", instr_pc, 0);

    // Streaming from RESET_PC with a 1-cycle memory
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("first_valid_cycle", 32'(first_valid), 3);

    // Stall the core: only DEPTH requests may be taken
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    acc_log.delete();
    tick();
    redirect_valid = 1'b0;
    repeat (15) tick();
    #1;
    chk("held_accepts", 32'(acc_log.size()), 2);
    chk("held_addr0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
    chk("held_addr1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, 32'h4);
    chk("held_stall", 32'(mem_req_valid), 0);
    chk("held_valid", 32'(instr_valid), 1);
    chk("held_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (10) tick();

    // Redirect with two requests in flight
    lat = 3;
    repeat (6) tick();
    n = 0;
    while (!(pend.size() == 2 && !mem_rsp_valid) && n < 50) begin
      tick();
      n++;
    end
    chk("two_outstanding", 32'(pend.size()), 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    acc_log.delete();
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (acc_log.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk("redir_first_addr", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF,
        32'h200);
    repeat (20) tick();

    // Redirect landing on a response cycle
    lat = 2;
    n = 0;
    while (!mem_rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("rsp_coincide", 32'(mem_rsp_valid), 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    repeat (20) tick();

    // Address wrap at the top of memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    acc_log.delete();
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (acc_log.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("wrap_addr0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF,
        32'hFFFF_FFFC);
    chk("wrap_addr1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF,
        32'h0000_0000);
    repeat (10) tick();

    // Random ready/latency with periodic redirects
    rand_mem = 1;
    for (int i = 0; i < 600; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      if (redirect_valid) begin
        redirect_valid = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
      end
    end
    redirect_valid = 1'b0;
    rand_mem       = 0;
    instr_ready    = 1'b1;
    repeat (20) tick();

    // Reset in the middle of traffic
    lat = 3;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    #1;
    chk("midrst_req_valid", 32'(mem_req_valid), 0);
    chk("midrst_instr_valid", 32'(instr_valid), 0);
    chk("midrst_instr_pc", instr_pc, 0);
    tick();
    rst = 1'b0;
    lat = 1;
    repeat (15) tick();
    chk("midrst_first_valid", 32'(first_valid), 3);
    chk("handshake_volume", 32'(hs >= 100), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
